bin_to_bcd_seq: RTL and testbench



---
 rtl/bin_to_bcd_seq.sv | 123 ++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
// Multi-cycle binary-to-BCD converter (shift-and-add-3), optional signed input and overflow flag.
// Latency BIN_W+1 cycles start->done; start is ignored while busy, no queueing.
module bin_to_bcd_seq #(
    parameter int BIN_W  = 12,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  sgn,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  neg,
    output logic                  overflow
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BIN_W-1:0]    bin_sr_q, bin_sr_d;
    logic [BCD_W-1:0]    work_q, work_d;
    logic                acc_ovf_q, acc_ovf_d;
    logic                sign_q, sign_d;
    logic [BCD_W-1:0]    bcd_q, bcd_d;
    logic                neg_q, neg_d;
    logic                ovf_q, ovf_d;
    logic                done_q, done_d;

    logic [BCD_W-1:0]    adj;
    logic [BIN_W-1:0]    mag;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bin_sr_d  = bin_sr_q;
        work_d    = work_q;
        acc_ovf_d = acc_ovf_q;
        sign_d    = sign_q;
        bcd_d     = bcd_q;
        neg_d     = neg_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;

        adj = work_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (work_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
            end
        end

        // Negating the most negative value wraps back to itself, which is the correct unsigned magnitude.
        mag = bin;
        if (sgn && bin[BIN_W-1]) begin
            mag = ~bin + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    bin_sr_d  = mag;
                    sign_d    = sgn && bin[BIN_W-1];
                    work_d    = '0;
                    acc_ovf_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                work_d    = {adj[BCD_W-2:0], bin_sr_q[BIN_W-1]};
                bin_sr_d  = {bin_sr_q[BIN_W-2:0], 1'b0};
                acc_ovf_d = acc_ovf_q | adj[BCD_W-1];
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(BIN_W - 1)) begin
                    bcd_d   = work_d;
                    neg_d   = sign_q;
                    ovf_d   = acc_ovf_d;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bin_sr_q  <= '0;
            work_q    <= '0;
            acc_ovf_q <= 1'b0;
            sign_q    <= 1'b0;
            bcd_q     <= '0;
            neg_q     <= 1'b0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bin_sr_q  <= bin_sr_d;
            work_q    <= work_d;
            acc_ovf_q <= acc_ovf_d;
            sign_q    <= sign_d;
            bcd_q     <= bcd_d;
            neg_q     <= neg_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
        end
    end

    assign busy     = (state_q == SHIFT);
    assign done     = done_q;
    assign bcd      = bcd_q;
    assign neg      = neg_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench: stimulus pushes expected results, per-instance monitors check done/busy/results.
module tb_bin_to_bcd_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start0 = 1'b0, sgn0 = 1'b0;
    logic [11:0] bin0 = '0;
    logic        busy0, done0, neg0, ovf0;
    logic [15:0] bcd0;

    logic        start1 = 1'b0, sgn1 = 1'b0;
    logic [11:0] bin1 = '0;
    logic        busy1, done1, neg1, ovf1;
    logic [11:0] bcd1;

    bin_to_bcd_seq #(.BIN_W(12), .DIGITS(4)) dut4 (
        .clk(clk), .rst(rst), .start(start0), .sgn(sgn0), .bin(bin0),
        .busy(busy0), .done(done0), .bcd(bcd0), .neg(neg0), .overflow(ovf0)
    );

    bin_to_bcd_seq #(.BIN_W(12), .DIGITS(3)) dut3 (
        .clk(clk), .rst(rst), .start(start1), .sgn(sgn1), .bin(bin1),
        .busy(busy1), .done(done1), .bcd(bcd1), .neg(neg1), .overflow(ovf1)
    );

    typedef struct {
        logic [15:0] bcd;
        logic        neg;
        logic        ovf;
        int          done_cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    exp_t e0, e1;
    logic bexp0, bexp1;

    always @(negedge clk) begin
        if (!rst) begin
            bexp0 = (q0.size() > 0) && (cyc > q0[0].done_cyc - 13) && (cyc < q0[0].done_cyc);
            chk("busy4", busy0, bexp0);
            if (done0) begin
                if (q0.size() == 0) begin
                    flag("unexpected_done4");
                end else begin
                    e0 = q0.pop_front();
                    chk("done_cycle4", cyc, e0.done_cyc);
                    chk("bcd4", bcd0, e0.bcd);
                    chk("neg4", neg0, e0.neg);
                    chk("ovf4", ovf0, e0.ovf);
                end
            end else if (q0.size() > 0 && cyc >= q0[0].done_cyc) begin
                flag("missing_done4");
                void'(q0.pop_front());
            end

            bexp1 = (q1.size() > 0) && (cyc > q1[0].done_cyc - 13) && (cyc < q1[0].done_cyc);
            chk("busy3", busy1, bexp1);
            if (done1) begin
                if (q1.size() == 0) begin
                    flag("unexpected_done3");
                end else begin
                    e1 = q1.pop_front();
                    chk("done_cycle3", cyc, e1.done_cyc);
                    chk("bcd3", {4'h0, bcd1}, e1.bcd);
                    chk("neg3", neg1, e1.neg);
                    chk("ovf3", ovf1, e1.ovf);
                end
            end else if (q1.size() > 0 && cyc >= q1[0].done_cyc) begin
                flag("missing_done3");
                void'(q1.pop_front());
            end
        end
    end

    // Called just after a rising edge; returns one cycle after start was presented.
    task automatic issue0(input logic s, input logic [11:0] b,
                          input logic [15:0] xb, input logic xn, input logic xo);
        int n = 0;
        while (busy0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy0) flag("timeout4");
        sgn0 = s; bin0 = b; start0 = 1'b1;
        q0.push_back('{xb, xn, xo, cyc + 13});
        @(posedge clk); #1;
        start0 = 1'b0; bin0 = ~b; sgn0 = ~s;
    endtask

    task automatic issue1(input logic s, input logic [11:0] b,
                          input logic [15:0] xb, input logic xn, input logic xo);
        int n = 0;
        while (busy1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy1) flag("timeout3");
        sgn1 = s; bin1 = b; start1 = 1'b1;
        q1.push_back('{xb, xn, xo, cyc + 13});
        @(posedge clk); #1;
        start1 = 1'b0; bin1 = ~b; sgn1 = ~s;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy0, 1'b0);
        chk("rst_done", done0, 1'b0);
        chk("rst_bcd", bcd0, 16'h0000);
        chk("rst_neg", neg0, 1'b0);
        chk("rst_ovf", ovf0, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Unsigned full scale, then back-to-back starts on the done cycle
        issue0(1'b0, 12'hFFF, 16'h4095, 1'b0, 1'b0);
        issue0(1'b0, 12'd0,   16'h0000, 1'b0, 1'b0);
        issue0(1'b0, 12'd1000, 16'h1000, 1'b0, 1'b0);

        // Signed mode
        issue0(1'b1, 12'hFFF, 16'h0001, 1'b1, 1'b0);
        issue0(1'b1, 12'h800, 16'h2048, 1'b1, 1'b0);
        issue0(1'b1, 12'h7FF, 16'h2047, 1'b0, 1'b0);
        issue0(1'b0, 12'h800, 16'h2048, 1'b0, 1'b0);
        issue0(1'b1, 12'h000, 16'h0000, 1'b0, 1'b0);

        // Start pulses in cycles 3 and 12 of a conversion must be ignored
        issue0(1'b0, 12'd123, 16'h0123, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        start0 = 1'b1; bin0 = 12'd999;
        @(posedge clk); #1;
        start0 = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        start0 = 1'b1; bin0 = 12'd999;
        @(posedge clk); #1;
        start0 = 1'b0;

        // Reset in cycle 6 aborts the conversion with no done
        issue0(1'b0, 12'd777, 16'h0777, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        void'(q0.pop_back());
        chk("abort_busy", busy0, 1'b0);
        chk("abort_done", done0, 1'b0);
        chk("abort_bcd", bcd0, 16'h0000);
        chk("abort_neg", neg0, 1'b0);
        issue0(1'b0, 12'd2500, 16'h2500, 1'b0, 1'b0);

        // Three-digit instance: overflow boundary
        issue1(1'b0, 12'd4095, 16'h0095, 1'b0, 1'b1);
        issue1(1'b0, 12'd999,  16'h0999, 1'b0, 1'b0);
        issue1(1'b1, 12'hC18,  16'h0000, 1'b1, 1'b1);
        issue1(1'b0, 12'd1000, 16'h0000, 1'b0, 1'b1);

        repeat (20) @(posedge clk);
        #1;
        chk("q4_drained", q0.size(), 0);
        chk("q3_drained", q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
